// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon host-side stream adapter.
package ascon_pack;

  typedef logic [63:0] u64_t;
  typedef logic [31:0] u32_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COMPLETE = 2'd2
  } adapter_state_e;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/word_packer.sv
// Packs 32-bit host words into 64-bit FIFO words for one stream (AD or PT),
// zero-filling the lower half when the message ends on an upper half.
module word_packer
  import ascon_pack::*;
#(
  parameter int WORD_CW = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               active,
  input  logic [WORD_CW-1:0] words,
  input  logic               wr_en,
  input  u32_t               wr_data,
  input  logic               full,
  output logic               push,
  output u64_t               data,
  output logic               pending,
  output logic               done
);

  u64_t               pack_reg, pack_next;
  logic               half_reg, half_next;
  logic               pend_reg, pend_next;
  logic               done_reg, done_next;
  logic [WORD_CW-1:0] cnt_reg, cnt_next;
  logic               last_word;

  assign last_word = (cnt_reg == WORD_CW'(1));
  assign push      = pend_reg & ~full & ~start;
  assign data      = pack_reg;
  assign pending   = pend_reg;
  assign done      = done_reg;

  always_comb begin
    pack_next = pack_reg;
    half_next = half_reg;
    pend_next = pend_reg;
    cnt_next  = cnt_reg;
    done_next = done_reg;
    if (start) begin
      pack_next = '0;
      half_next = 1'b0;
      pend_next = 1'b0;
      cnt_next  = words;
      done_next = (words == '0);
    end else if (active) begin
      if (push) pend_next = 1'b0;
      if (wr_en) begin
        cnt_next = cnt_reg - 1'b1;
        if (!half_reg) begin
          // A message ending on an upper half completes with a zero lower half.
          pack_next = {wr_data, 32'h0};
          half_next = ~last_word;
          pend_next = last_word;
        end else begin
          pack_next[31:0] = wr_data;
          half_next       = 1'b0;
          pend_next       = 1'b1;
        end
      end
      done_next = (cnt_next == '0) && !pend_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_reg <= '0;
      half_reg <= 1'b0;
      pend_reg <= 1'b0;
      done_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      pack_reg <= pack_next;
      half_reg <= half_next;
      pend_reg <= pend_next;
      done_reg <= done_next;
      cnt_reg  <= cnt_next;
    end
  end

endmodule

// File: rtl/ascon_stream_adapter.sv
// Host-side adapter for the Ascon core FIFOs: packs 32-bit writes into the
// AD/PT FIFOs and unpacks CT FIFO words into 32-bit host reads.
module ascon_stream_adapter
  import ascon_pack::*;
#(
  parameter int DATA_AW = 7,
  parameter int WORD_CW = DATA_AW - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [DATA_AW-1:0] ad_size_i,
  input  logic [DATA_AW-1:0] pt_size_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic               wr_sel_i,
  input  u32_t               wr_data_i,
  output logic               ad_push_o,
  output u64_t               ad_data_o,
  input  logic               ad_full_i,
  output logic               pt_push_o,
  output u64_t               pt_data_o,
  input  logic               pt_full_i,
  output logic               ct_pop_o,
  input  u64_t               ct_data_i,
  input  logic               ct_empty_i,
  output logic               rd_valid_o,
  input  logic               rd_ready_i,
  output u32_t               rd_data_o,
  output logic               ad_done_o,
  output logic               pt_done_o,
  output logic               ct_done_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int WB_SH = $clog2(WORD_BYTES);

  adapter_state_e     state_reg;
  logic               armed_reg, err_reg, active;
  logic [WORD_CW-1:0] ad_words, pt_words;
  logic [WORD_CW-1:0] words_arr [2];
  u64_t               data_arr [2];
  logic [1:0]         full_vec, push_vec, pend_vec, done_vec, wr_en_vec;
  logic               wr_fire, wr_keep;

  assign ad_words = WORD_CW'(({1'b0, ad_size_i} + (DATA_AW + 1)'(WORD_BYTES - 1)) >> WB_SH);
  assign pt_words = WORD_CW'(({1'b0, pt_size_i} + (DATA_AW + 1)'(WORD_BYTES - 1)) >> WB_SH);

  assign active = (state_reg == ACTIVE);

  // armed_reg keeps wr_ready_o low in the reset cycle so every output reads 0.
  assign wr_ready_o = armed_reg & ~start_i & (~active | ~pend_vec[wr_sel_i]);
  assign wr_fire    = wr_valid_i & wr_ready_o;
  assign wr_keep    = wr_fire & active & ~done_vec[wr_sel_i];
  assign wr_en_vec  = {wr_keep & wr_sel_i, wr_keep & ~wr_sel_i};

  assign words_arr[0] = ad_words;
  assign words_arr[1] = pt_words;
  assign full_vec     = {pt_full_i, ad_full_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pack
      word_packer #(.WORD_CW(WORD_CW)) u_pack (
        .clk     (clk),
        .rst     (rst),
        .start   (start_i),
        .active  (active),
        .words   (words_arr[gi]),
        .wr_en   (wr_en_vec[gi]),
        .wr_data (wr_data_i),
        .full    (full_vec[gi]),
        .push    (push_vec[gi]),
        .data    (data_arr[gi]),
        .pending (pend_vec[gi]),
        .done    (done_vec[gi])
      );
    end
  endgenerate

  assign ad_push_o = push_vec[0];
  assign pt_push_o = push_vec[1];
  assign ad_data_o = data_arr[0];
  assign pt_data_o = data_arr[1];
  assign ad_done_o = done_vec[0];
  assign pt_done_o = done_vec[1];

  u64_t               ct_reg, ct_next;
  logic               rd_valid_reg, rd_valid_next, rd_half_reg, rd_half_next;
  logic               ct_done_reg, ct_done_next, rd_fire, ct_pop;
  logic [WORD_CW-1:0] ct_cnt_reg, ct_cnt_next;

  assign rd_fire = rd_valid_reg & rd_ready_i;

  always_comb begin
    ct_next       = ct_reg;
    rd_valid_next = rd_valid_reg;
    rd_half_next  = rd_half_reg;
    ct_cnt_next   = ct_cnt_reg;
    ct_done_next  = ct_done_reg;
    ct_pop        = 1'b0;
    if (start_i) begin
      ct_next       = '0;
      rd_valid_next = 1'b0;
      rd_half_next  = 1'b0;
      ct_cnt_next   = pt_words;
      ct_done_next  = (pt_words == '0);
    end else if (active) begin
      if (rd_fire) begin
        ct_cnt_next = ct_cnt_reg - 1'b1;
        if (!rd_half_reg && ct_cnt_next != '0) begin
          rd_half_next = 1'b1;
        end else begin
          rd_valid_next = 1'b0;
          rd_half_next  = 1'b0;
        end
      end
      // A refill may coincide with the handshake that drains the register.
      if (!rd_valid_next && ct_cnt_next != '0 && !ct_empty_i) begin
        ct_pop        = 1'b1;
        ct_next       = ct_data_i;
        rd_valid_next = 1'b1;
        rd_half_next  = 1'b0;
      end
      ct_done_next = (ct_cnt_next == '0) && !rd_valid_next;
    end
  end

  assign ct_pop_o   = ct_pop;
  assign rd_valid_o = rd_valid_reg;
  assign rd_data_o  = rd_half_reg ? ct_reg[31:0] : ct_reg[63:32];
  assign ct_done_o  = ct_done_reg;
  assign busy_o     = active;
  assign err_o      = err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      armed_reg    <= 1'b0;
      err_reg      <= 1'b0;
      ct_reg       <= '0;
      rd_valid_reg <= 1'b0;
      rd_half_reg  <= 1'b0;
      ct_cnt_reg   <= '0;
      ct_done_reg  <= 1'b0;
    end else begin
      armed_reg    <= 1'b1;
      ct_reg       <= ct_next;
      rd_valid_reg <= rd_valid_next;
      rd_half_reg  <= rd_half_next;
      ct_cnt_reg   <= ct_cnt_next;
      ct_done_reg  <= ct_done_next;
      if (start_i) begin
        state_reg <= ACTIVE;
        err_reg   <= 1'b0;
      end else begin
        if (wr_fire && !wr_keep) err_reg <= 1'b1;
        case (state_reg)
          IDLE:     state_reg <= IDLE;
          ACTIVE:   if (done_vec[0] && done_vec[1] && ct_done_reg) state_reg <= COMPLETE;
          COMPLETE: state_reg <= COMPLETE;
          default:  state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ascon_stream_adapter.sv
// Self-checking bench for ascon_stream_adapter: a message-level model predicts
// pushes, reads and the error flag; directed vectors pin the model with literals.
module tb_ascon_stream_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [6:0]  ad_size_i = '0, pt_size_i = '0;
  logic        wr_valid_i = 1'b0, wr_sel_i = 1'b0;
  logic [31:0] wr_data_i = '0;
  logic        wr_ready_o, ad_push_o, pt_push_o, ct_pop_o, rd_valid_o;
  logic [63:0] ad_data_o, pt_data_o;
  logic        ad_full_i = 1'b0, pt_full_i = 1'b0;
  logic [63:0] ct_data_i;
  logic        ct_empty_i;
  logic        rd_ready_i = 1'b1;
  logic [31:0] rd_data_o;
  logic        ad_done_o, pt_done_o, ct_done_o, busy_o, err_o;

  ascon_stream_adapter #(.DATA_AW(7)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ad_size_i(ad_size_i), .pt_size_i(pt_size_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_sel_i(wr_sel_i), .wr_data_i(wr_data_i),
    .ad_push_o(ad_push_o), .ad_data_o(ad_data_o), .ad_full_i(ad_full_i),
    .pt_push_o(pt_push_o), .pt_data_o(pt_data_o), .pt_full_i(pt_full_i),
    .ct_pop_o(ct_pop_o), .ct_data_i(ct_data_i), .ct_empty_i(ct_empty_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .ad_done_o(ad_done_o), .pt_done_o(pt_done_o), .ct_done_o(ct_done_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int n_ad_push = 0, n_pt_push = 0, n_pop = 0, n_rd = 0;
  logic [63:0] last_ad = '0;
  logic [63:0] ad_exp_q[$], pt_exp_q[$], ct_q[$];
  logic [31:0] rd_exp_q[$], rd_log[$];

  // Message-level model: words still expected per stream, buffered halves, error flag.
  int          m_left[2];
  int          m_ct_left = 0;
  logic        m_err = 1'b0;
  logic [31:0] mb_ad[$], mb_pt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int nwords(input int sz);
    return (sz + 3) / 4;
  endfunction

  function automatic logic [63:0] pair(input logic [31:0] q[$]);
    return {q[0], (q.size() == 2) ? q[1] : 32'h0};
  endfunction

  task automatic model_reset();
    m_left[0] = 0; m_left[1] = 0; m_ct_left = 0; m_err = 1'b0;
    mb_ad.delete(); mb_pt.delete(); ct_q.delete(); rd_log.delete();
  endtask

  task automatic model_start(input int ad, input int pt);
    model_reset();
    m_left[0] = nwords(ad); m_left[1] = nwords(pt); m_ct_left = nwords(pt);
  endtask

  task automatic model_write(input logic sel, input logic [31:0] d);
    if (m_left[sel] == 0) m_err = 1'b1;
    else begin
      m_left[sel]--;
      if (!sel) begin
        mb_ad.push_back(d);
        if (mb_ad.size() == 2 || m_left[0] == 0) begin ad_exp_q.push_back(pair(mb_ad)); mb_ad.delete(); end
      end else begin
        mb_pt.push_back(d);
        if (mb_pt.size() == 2 || m_left[1] == 0) begin pt_exp_q.push_back(pair(mb_pt)); mb_pt.delete(); end
      end
    end
  endtask

  task automatic load_ct(input logic [63:0] w);
    ct_q.push_back(w);
    if (m_ct_left > 0) begin rd_exp_q.push_back(w[63:32]); m_ct_left--; end
    if (m_ct_left > 0) begin rd_exp_q.push_back(w[31:0]);  m_ct_left--; end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_start(input int ad, input int pt);
    ad_size_i = 7'(ad); pt_size_i = 7'(pt); start_i = 1'b1;
    tick();
    model_start(ad, pt);
    start_i = 1'b0;
  endtask

  task automatic wr(input logic sel, input logic [31:0] d);
    bit acc = 1'b0;
    wr_valid_i = 1'b1; wr_sel_i = sel; wr_data_i = d;
    for (int t = 0; t < 50 && !acc; t++) begin
      #1; acc = wr_ready_o;
      tick();
    end
    wr_valid_i = 1'b0;
    if (acc) model_write(sel, d);
    else chk("wr_accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((ad_exp_q.size() + pt_exp_q.size() + rd_exp_q.size()) != 0 && t < 100) begin
      tick(); t++;
    end
    chk(name, 64'(ad_exp_q.size() + pt_exp_q.size() + rd_exp_q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_flags"}, 64'({wr_ready_o, ad_push_o, pt_push_o, ct_pop_o, rd_valid_o,
                               ad_done_o, pt_done_o, ct_done_o, busy_o, err_o}), 64'd0);
    chk({name, "_data"}, ad_data_o | pt_data_o | 64'(rd_data_o), 64'd0);
  endtask

  // Compare process: every cycle out of reset, check pushes, reads and err_o.
  initial begin : monitor
    bit pop;
    ct_data_i = '0; ct_empty_i = 1'b1;
    forever begin
      @(negedge clk);
      pop = 1'b0;
      if (!rst) begin
        chk("err_o", 64'(err_o), 64'(m_err));
        if (ad_push_o) begin
          n_ad_push++; last_ad = ad_data_o;
          if (ad_exp_q.size() == 0) chk("ad_push_extra", 64'd1, 64'd0);
          else chk("ad_data", ad_data_o, ad_exp_q.pop_front());
        end
        if (pt_push_o) begin
          n_pt_push++;
          if (pt_exp_q.size() == 0) chk("pt_push_extra", 64'd1, 64'd0);
          else chk("pt_data", pt_data_o, pt_exp_q.pop_front());
        end
        if (rd_valid_o && rd_ready_i) begin
          n_rd++; rd_log.push_back(rd_data_o);
          if (rd_exp_q.size() == 0) chk("rd_extra", 64'd1, 64'd0);
          else chk("rd_data", 64'(rd_data_o), 64'(rd_exp_q.pop_front()));
        end
        if (ct_pop_o) begin
          pop = 1'b1; n_pop++;
          if (ct_q.size() == 0) chk("pop_on_empty", 64'd1, 64'd0);
        end
      end
      @(posedge clk); #1;
      if (pop && ct_q.size() != 0) void'(ct_q.pop_front());
      ct_empty_i = (ct_q.size() == 0);
      ct_data_i  = (ct_q.size() != 0) ? ct_q[0] : 64'h0;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stimulus
    int base_ad, base_pt, base_pop, base_rd;
    model_reset();
    repeat (3) tick();
    #1 chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Write in IDLE is accepted and dropped.
    wr(1'b0, 32'hDEADBEEF);
    #1 chk("idle_write_err", 64'(err_o), 64'd1);
    chk("idle_busy", 64'(busy_o), 64'd0);

    // AD 12 bytes, PT empty.
    base_pt = n_pt_push;
    do_start(12, 0);
    #1 chk("pt_done_first_cycle", 64'(pt_done_o), 64'd1);
    chk("busy_active", 64'(busy_o), 64'd1);
    wr(1'b0, 32'h00010203); wr(1'b0, 32'h04050607); wr(1'b0, 32'h08090A0B);
    drain("ad12_drain");
    tick();
    #1 chk("ad12_done", 64'(ad_done_o), 64'd1);
    chk("ad12_last_push", last_ad, 64'h08090A0B00000000);
    chk("ad12_no_pt_push", 64'(n_pt_push - base_pt), 64'd0);
    tick(); tick();
    #1 chk("complete_not_busy", 64'(busy_o), 64'd0);
    wr(1'b0, 32'h12345678);
    #1 chk("complete_write_err", 64'(err_o), 64'd1);

    // PT 16 bytes with the FIFO full across the first completed word.
    base_pt = n_pt_push;
    pt_full_i = 1'b1;
    do_start(0, 16);
    wr(1'b1, 32'hA0A1A2A3); wr(1'b1, 32'hB0B1B2B3);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_wr_ready", 64'(wr_ready_o), 64'd0);
      chk("stall_no_push", 64'(pt_push_o), 64'd0);
      chk("stall_pt_data", pt_data_o, 64'hA0A1A2A3B0B1B2B3);
      tick();
    end
    pt_full_i = 1'b0;
    drain("stall_first_drain");
    wr(1'b1, 32'hC0C1C2C3); wr(1'b1, 32'hD0D1D2D3);
    drain("stall_drain");
    tick();
    #1 chk("stall_push_count", 64'(n_pt_push - base_pt), 64'd2);
    chk("stall_pt_done", 64'(pt_done_o), 64'd1);

    // CT unpack, 9 bytes -> three reads, lower half of the second word discarded.
    do_start(0, 9);
    base_pop = n_pop; base_rd = n_rd;
    load_ct(64'hAABBCCDD11223344); load_ct(64'h5566778899AABBCC);
    drain("ct9_drain");
    tick(); tick();
    #1 chk("ct9_pops", 64'(n_pop - base_pop), 64'd2);
    chk("ct9_reads", 64'(n_rd - base_rd), 64'd3);
    chk("ct9_done", 64'(ct_done_o), 64'd1);
    chk("ct9_rd0", 64'(rd_log[0]), 64'hAABBCCDD);
    chk("ct9_rd1", 64'(rd_log[1]), 64'h11223344);
    chk("ct9_rd2", 64'(rd_log[2]), 64'h55667788);

    // CT unpack, 32 bytes with rd_ready toggling every cycle.
    do_start(0, 32);
    base_pop = n_pop; base_rd = n_rd;
    for (int i = 0; i < 4; i++) load_ct({32'h10000000 + 32'(i), 32'h20000000 + 32'(i)});
    for (int t = 0; t < 100 && rd_exp_q.size() != 0; t++) begin
      rd_ready_i = ~rd_ready_i;
      tick();
    end
    rd_ready_i = 1'b1;
    drain("ct32_drain");
    tick(); tick();
    #1 chk("ct32_pops", 64'(n_pop - base_pop), 64'd4);
    chk("ct32_reads", 64'(n_rd - base_rd), 64'd8);
    chk("ct32_done", 64'(ct_done_o), 64'd1);

    // AD write after ad_done is dropped; err holds until the next start.
    base_ad = n_ad_push;
    do_start(4, 4);
    load_ct(64'h0F0E0D0C0B0A0908);
    wr(1'b0, 32'h11112222);
    drain("late_ad_drain");
    tick();
    #1 chk("late_ad_done", 64'(ad_done_o), 64'd1);
    chk("late_ad_data", last_ad, 64'h1111222200000000);
    wr(1'b0, 32'h33334444);
    #1 chk("late_write_err", 64'(err_o), 64'd1);
    wr(1'b1, 32'h55556666);
    drain("late_pt_drain");
    repeat (3) tick();
    #1 chk("late_ad_push_count", 64'(n_ad_push - base_ad), 64'd1);
    chk("err_sticky", 64'(err_o), 64'd1);

    // Restart after 1 of 3 AD words: partial word is discarded.
    base_ad = n_ad_push;
    do_start(12, 0);
    #1 chk("restart_err_cleared", 64'(err_o), 64'd0);
    wr(1'b0, 32'h99990000);
    do_start(4, 0);
    repeat (3) tick();
    #1 chk("restart_no_push", 64'(n_ad_push - base_ad), 64'd0);
    wr(1'b0, 32'hCAFEF00D);
    drain("restart_drain");
    #1 chk("restart_push_data", last_ad, 64'hCAFEF00D00000000);
    chk("restart_push_count", 64'(n_ad_push - base_ad), 64'd1);

    // Reset mid-transfer.
    do_start(12, 8);
    load_ct(64'h0123456789ABCDEF);
    wr(1'b0, 32'h77778888);
    rst = 1'b1;
    tick();
    model_reset();
    #1 chk_all_zero("mid_reset");
    rst = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
